miriscv_irq_ctrl: RTL
=====================

Name: miriscv_irq_ctrl

Overview:
Interrupt controller directly upstream of the miriscv core's interrupt input. It collects level-sensitive requests from memory-mapped peripherals and qualifies them with the core's MIE mask. It presents one selected interrupt with its mcause code to the core, holds it until the core signals mret, then pulses an acknowledge back to the serviced peripheral.

Parameters:
IRQ_NUM, 16, number of request lines (1..32)
CAUSE_BASE, 32'h8000_0010, mcause value for line 0; line k reports CAUSE_BASE + k

Ports:
clk_i  input  1  core clock, all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
irq_req_i  input  IRQ_NUM  level-sensitive peripheral requests
mie_i  input  IRQ_NUM  per-line enable mask from core CSR
irq_ret_i  input  1  one-cycle pulse from core on mret
irq_o  output  1  interrupt request to core (registered)
irq_cause_o  output  32  mcause value of the selected line (registered)
irq_ack_o  output  IRQ_NUM  one-hot acknowledge to peripherals (registered)

Behaviour:
- Reset: synchronous, active-high, evaluated only on clk_i rising edge. irq_o=0, irq_cause_o=0, irq_ack_o=0, state=IDLE, last_id=IRQ_NUM-1. Reset overrides every other input in the same cycle.
- pending = irq_req_i & mie_i, combinational, sampled only in IDLE.
- FSM states IDLE, SERVE, ACK.
- IDLE:
  - If pending!=0: select one id per the arbitration rule, latch id, irq_cause_o<=CAUSE_BASE+id, irq_o<=1, go to SERVE. Latency from request to irq_o is 1 cycle.
  - If pending==0: stay in IDLE; irq_cause_o holds its last value.
- SERVE:
  - irq_o stays 1 and irq_cause_o is stable.
  - Changes on irq_req_i or mie_i are ignored; a dropped request does not cancel service.
  - On irq_ret_i=1: irq_o<=0, irq_ack_o<=one-hot(id), last_id<=id, go to ACK.
- ACK: lasts exactly one cycle. irq_ack_o is high for this cycle only. Next state is IDLE with irq_ack_o<=0.
  - The earliest re-selection happens in the IDLE cycle after ACK, so irq_o is low for at least 2 cycles between services. This gives the peripheral time to drop its level.
- irq_ret_i in IDLE or ACK: ignored, no state change, no ack.
- Arbitration, default: fixed priority, lowest index wins.
- Widths:
  - id is $clog2(IRQ_NUM) bits, minimum 1.
  - irq_cause_o is computed as a 32-bit add with no wrap concerns (IRQ_NUM<=32).
- Only one interrupt is in flight at a time; no nesting.

Optional Feature:
MIRISCV_IRQ_RR_EN
- Defined: round-robin arbitration. The search starts at (last_id+1) mod IRQ_NUM and wraps around; the first pending line found wins. last_id updates only on irq_ret_i in SERVE. Because last_id resets to IRQ_NUM-1, the first selection after reset equals fixed priority.
- Undefined: fixed lowest-index priority. The last_id register may be omitted.

Test Plan:
1. rst_i=1 for 3 cycles with irq_req_i=16'hFFFF, mie_i=16'hFFFF -> irq_o=0, irq_cause_o=0, irq_ack_o=0 throughout. First irq_o=1 occurs 1 cycle after rst_i falls, with cause 32'h8000_0010.
2. mie_i=16'hFFFF, irq_req_i=16'h0008 -> next cycle irq_o=1, irq_cause_o=32'h8000_0013. Pulse irq_ret_i 5 cycles later -> next cycle irq_o=0, irq_ack_o=16'h0008 for exactly 1 cycle. Drop request on ack -> irq_o stays 0.
3. irq_req_i=16'h0020, mie_i=16'h0000 for 20 cycles -> irq_o=0. Set mie_i=16'h0020 -> irq_o=1 one cycle later, cause 32'h8000_0015. Clear mie_i during SERVE -> irq_o stays 1 until irq_ret_i.
4. irq_req_i=16'h0012 held permanently, irq_ret_i pulsed every 6 cycles -> served id sequence:
   - without MIRISCV_IRQ_RR_EN: 1,1,1,1 (causes 0x8000_0011 repeated)
   - with MIRISCV_IRQ_RR_EN: 1,4,1,4 (causes 0x8000_0011/0x8000_0014 alternating)
   - in both cases, 2-cycle irq_o gap between services.
5. rst_i=1 for 1 cycle while in SERVE (cause 0x8000_0012) -> next edge irq_o=0, irq_cause_o=0, irq_ack_o=0. No ack is ever issued for the aborted id.
6. irq_ret_i pulses while in IDLE with no pending requests, and while in ACK -> no state change, irq_ack_o remains 0 (except the legitimate ACK-cycle pulse).

Source files
------------

// File: rtl/miriscv_irq_ctrl.sv
// ---------------------------------------------------------------------------
// miriscv_irq_ctrl
//
// Interrupt controller in front of the miriscv core interrupt input.
// Level-sensitive peripheral requests are masked with the core MIE bits, one
// line is selected and presented to the core together with its mcause code.
// The selection is held until the core signals mret, after which a one-cycle
// one-hot acknowledge is returned to the serviced peripheral.
//
// Optional build macro:
//   MIRISCV_IRQ_RR_EN  - round-robin arbitration starting after the last
//                        serviced line; when undefined, the lowest pending
//                        index wins.
//
// Ports:
//   clk_i        core clock, all state updates on rising edge
//   rst_i        synchronous active-high reset
//   irq_req_i    level-sensitive peripheral requests (IRQ_NUM)
//   mie_i        per-line enable mask from core CSR (IRQ_NUM)
//   irq_ret_i    one-cycle pulse from core on mret
//   irq_o        registered interrupt request to core
//   irq_cause_o  registered mcause of the selected line
//   irq_ack_o    registered one-hot acknowledge to peripherals (IRQ_NUM)
//
// Handshake: irq_o rises one cycle after a pending line is seen in IDLE and
// stays high until irq_ret_i is sampled in SERVE; irq_ret_i outside SERVE is
// ignored. irq_ack_o is high for exactly the one ACK cycle.
// ---------------------------------------------------------------------------
module miriscv_irq_ctrl #(
    parameter int unsigned IRQ_NUM    = 16,
    parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IRQ_NUM-1:0] irq_req_i,
    input  logic [IRQ_NUM-1:0] mie_i,
    input  logic               irq_ret_i,
    output logic               irq_o,
    output logic [31:0]        irq_cause_o,
    output logic [IRQ_NUM-1:0] irq_ack_o
);

    localparam int unsigned ID_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               irq_q, irq_d;
    logic [31:0]        cause_q, cause_d;
    logic [IRQ_NUM-1:0] ack_q, ack_d;

    logic [IRQ_NUM-1:0] pending;
    logic               sel_found;
    logic [ID_W-1:0]    sel_id;

    assign pending = irq_req_i & mie_i;

`ifdef MIRISCV_IRQ_RR_EN
    logic [ID_W-1:0] last_id_q, last_id_d;

    // Search begins one past the last serviced line and wraps around.
    always_comb begin
        int unsigned idx;
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = 0;
        for (int k = 0; k < int'(IRQ_NUM); k++) begin
            idx = (int'(last_id_q) + 1 + k) % IRQ_NUM;
            if (!sel_found && pending[idx]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(idx);
            end
        end
    end
`else
    // Scan from the top down so the lowest pending index is the final winner.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int i = int'(IRQ_NUM) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        irq_d   = irq_q;
        cause_d = cause_q;
        ack_d   = '0;
`ifdef MIRISCV_IRQ_RR_EN
        last_id_d = last_id_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    id_d    = sel_id;
                    cause_d = CAUSE_BASE + {{(32-ID_W){1'b0}}, sel_id};
                    irq_d   = 1'b1;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                // Request/mask changes are ignored while a line is in service.
                if (irq_ret_i) begin
                    irq_d = 1'b0;
                    for (int i = 0; i < int'(IRQ_NUM); i++) begin
                        ack_d[i] = (id_q == ID_W'(i));
                    end
`ifdef MIRISCV_IRQ_RR_EN
                    last_id_d = id_q;
`endif
                    state_d = ACK;
                end
            end
            ACK: begin
                // One dead cycle lets the peripheral drop its level.
                state_d = IDLE;
            end
            default: begin
                irq_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            irq_q   <= 1'b0;
            cause_q <= '0;
            ack_q   <= '0;
`ifdef MIRISCV_IRQ_RR_EN
            last_id_q <= ID_W'(IRQ_NUM - 1);
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            irq_q   <= irq_d;
            cause_q <= cause_d;
            ack_q   <= ack_d;
`ifdef MIRISCV_IRQ_RR_EN
            last_id_q <= last_id_d;
`endif
        end
    end

    assign irq_o       = irq_q;
    assign irq_cause_o = cause_q;
    assign irq_ack_o   = ack_q;

endmodule
